memory_stage: RTL and testbench

Memory stage of the five-stage Y86-64 pipeline, directly downstream of the execute stage. It holds the M pipeline register, which captures the execute-stage outputs every clock, and a byte-addressed data memory. It performs the load or store for the instruction currently in M and drives `m_stat` back to execute for condition-code gating. It also drives `m_valM` and the M-register fields forward to write-back.

---
 rtl/memory_stage.sv | 132 +++++++++++++
 tb/tb_memory_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage: M pipeline register plus byte-addressed little-endian data memory.
// Loads are combinational from the array; stores commit on the edge that ends the M cycle.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        M_bubble,
  input  logic [0:3]  e_stat,
  input  logic [0:3]  e_icode,
  input  logic        e_Cnd,
  input  logic [0:63] e_valE,
  input  logic [0:63] e_valA,
  input  logic [0:3]  e_dstE,
  input  logic [0:3]  e_dstM,
  output logic [0:3]  M_stat,
  output logic [0:3]  M_icode,
  output logic        M_Cnd,
  output logic [0:63] M_valE,
  output logic [0:63] M_valA,
  output logic [0:3]  M_dstE,
  output logic [0:3]  M_dstM,
  output logic [0:3]  m_stat,
  output logic [0:63] m_valM
);

  localparam int          AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  localparam logic [0:3] S_AOK    = 4'b1000;
  localparam logic [0:3] S_ADR    = 4'b0010;
  localparam logic [0:3] I_NOP    = 4'h1;
  localparam logic [0:3] I_RMMOVQ = 4'h4;
  localparam logic [0:3] I_MRMOVQ = 4'h5;
  localparam logic [0:3] I_CALL   = 4'h8;
  localparam logic [0:3] I_RET    = 4'h9;
  localparam logic [0:3] I_PUSHQ  = 4'hA;
  localparam logic [0:3] I_POPQ   = 4'hB;
  localparam logic [0:3] R_NONE   = 4'hF;

  logic [0:3]  stat_q, stat_d;
  logic [0:3]  icode_q, icode_d;
  logic        cnd_q, cnd_d;
  logic [0:63] valE_q, valE_d;
  logic [0:63] valA_q, valA_d;
  logic [0:3]  dstE_q, dstE_d;
  logic [0:3]  dstM_q, dstM_d;

  logic [7:0]  mem_q [MEM_BYTES];

  always_comb begin
    stat_d  = e_stat;
    icode_d = e_icode;
    cnd_d   = e_Cnd;
    valE_d  = e_valE;
    valA_d  = e_valA;
    dstE_d  = e_dstE;
    dstM_d  = e_dstM;
    if (!rst_n || M_bubble) begin
      stat_d  = S_AOK;
      icode_d = I_NOP;
      cnd_d   = 1'b0;
      valE_d  = '0;
      valA_d  = '0;
      dstE_d  = R_NONE;
      dstM_d  = R_NONE;
    end
  end

  always_ff @(posedge clk) begin
    stat_q  <= stat_d;
    icode_q <= icode_d;
    cnd_q   <= cnd_d;
    valE_q  <= valE_d;
    valA_q  <= valA_d;
    dstE_q  <= dstE_d;
    dstM_q  <= dstM_d;
  end

  assign M_stat  = stat_q;
  assign M_icode = icode_q;
  assign M_Cnd   = cnd_q;
  assign M_valE  = valE_q;
  assign M_valA  = valA_q;
  assign M_dstE  = dstE_q;
  assign M_dstM  = dstM_q;

  logic        rd_op, wr_op, use_valA;
  logic        mem_en, addr_ok;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rd_word;
  logic [AW-1:0] base;

  always_comb begin
    rd_op    = 1'b0;
    wr_op    = 1'b0;
    use_valA = 1'b0;
    case (icode_q)
      I_MRMOVQ:                 rd_op = 1'b1;
      I_RET, I_POPQ:    begin rd_op = 1'b1; use_valA = 1'b1; end
      I_RMMOVQ, I_CALL, I_PUSHQ: wr_op = 1'b1;
      default: ;
    endcase
  end

  // Full 64-bit compare: addresses near 2^64 must not wrap into range.
  assign addr    = use_valA ? valA_q : valE_q;
  assign wdata   = valA_q;
  assign addr_ok = (addr <= MAX_ADDR);
  assign mem_en  = (stat_q == S_AOK) && (rd_op || wr_op);
  assign base    = addr_ok ? addr[AW-1:0] : '0;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 8; k++) begin
      rd_word[8*k +: 8] = mem_q[base + AW'(k)];
    end
  end

  assign m_valM = (mem_en && rd_op && addr_ok) ? rd_word : '0;
  assign m_stat = (mem_en && !addr_ok) ? S_ADR : stat_q;

  always_ff @(posedge clk) begin
    if (rst_n && mem_en && wr_op && addr_ok) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[base + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected M-register and memory results are queued
// when each instruction is driven and compared once it occupies the M stage.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n, M_bubble;
  logic [0:3]  e_stat, e_icode, e_dstE, e_dstM;
  logic        e_Cnd;
  logic [0:63] e_valE, e_valA;
  logic [0:3]  M_stat, M_icode, M_dstE, M_dstM, m_stat;
  logic        M_Cnd;
  logic [0:63] M_valE, M_valA, m_valM;

  memory_stage #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .M_bubble(M_bubble),
    .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd),
    .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .m_stat(m_stat), .m_valM(m_valM)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] AOK = 4'b1000, HLT = 4'b0100, ADR = 4'b0010, INS = 4'b0001;

  typedef struct {
    logic [3:0]  stat, icode;
    logic        cnd;
    logic [63:0] valE, valA;
    logic [3:0]  dstE, dstM, mstat;
    logic [63:0] mvalM;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  ref_mem [1024];
  logic        pend;
  logic [63:0] pend_addr, pend_data;
  int          errors = 0;
  int          checks = 0;

  // Presents one instruction to execute outputs, queues its expected M-cycle
  // results, and returns 1 time unit after the edge that loads it into M.
  task automatic drive(input logic rst, input logic bub, input logic [3:0] st,
                       input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] de, input logic [3:0] dm);
    exp_t        x;
    logic        rd, wr, c;
    logic [63:0] a;
    c = 1'($urandom_range(0, 1));
    rst_n = rst; M_bubble = bub; e_stat = st; e_icode = ic; e_Cnd = c;
    e_valE = ve; e_valA = va; e_dstE = de; e_dstM = dm;
    if (pend && rst)
      for (int k = 0; k < 8; k++) ref_mem[int'(pend_addr[9:0]) + k] = pend_data[8*k +: 8];
    pend = 1'b0;
    if (!rst || bub) begin
      x.stat = AOK; x.icode = 4'h1; x.cnd = 1'b0; x.valE = '0; x.valA = '0;
      x.dstE = 4'hF; x.dstM = 4'hF;
    end else begin
      x.stat = st; x.icode = ic; x.cnd = c; x.valE = ve; x.valA = va;
      x.dstE = de; x.dstM = dm;
    end
    x.mstat = x.stat;
    x.mvalM = '0;
    rd = (x.icode inside {4'h5, 4'h9, 4'hB});
    wr = (x.icode inside {4'h4, 4'h8, 4'hA});
    a  = (x.icode inside {4'h9, 4'hB}) ? x.valA : x.valE;
    if (x.stat == AOK && (rd || wr)) begin
      if (a > 64'd1016) x.mstat = ADR;
      else if (rd) begin
        for (int k = 0; k < 8; k++) x.mvalM[8*k +: 8] = ref_mem[int'(a[9:0]) + k];
      end else begin
        pend = 1'b1; pend_addr = a; pend_data = x.valA;
      end
    end
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, AOK, 4'h4, 64'h100, 64'h55, 4'h2, 4'h3);
      x = sbq.pop_front();
      checks += 8;
      if (M_icode !== 4'h1) begin errors++; $display("FAIL reset_icode got=%h want=1", M_icode); end
      if (M_dstE !== 4'hF) begin errors++; $display("FAIL reset_dstE got=%h want=f", M_dstE); end
      if (M_dstM !== 4'hF) begin errors++; $display("FAIL reset_dstM got=%h want=f", M_dstM); end
      if (M_stat !== AOK) begin errors++; $display("FAIL reset_Mstat got=%b want=1000", M_stat); end
      if (m_stat !== AOK) begin errors++; $display("FAIL reset_mstat got=%b want=1000", m_stat); end
      if (m_valM !== 64'h0) begin errors++; $display("FAIL reset_valM got=%h want=0", m_valM); end
      if (M_valE !== 64'h0 || M_valA !== 64'h0) begin
        errors++; $display("FAIL reset_vals got=%h/%h want=0/0", M_valE, M_valA);
      end
      if (M_Cnd !== x.cnd) begin errors++; $display("FAIL reset_cnd got=%b want=%b", M_Cnd, x.cnd); end
    end
    // Store sits in M while reset is asserted: its write must be dropped.
    drive(1'b1, 1'b0, AOK, 4'h4, 64'h100, 64'hCAFE, 4'hF, 4'hF);
    x = sbq.pop_front();
    checks += 1;
    if (M_icode !== 4'h4) begin errors++; $display("FAIL rststore_icode got=%h want=4", M_icode); end
    drive(1'b0, 1'b0, AOK, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    x = sbq.pop_front();
    drive(1'b1, 1'b0, AOK, 4'h5, 64'h100, 64'h0, 4'hF, 4'h2);
    x = sbq.pop_front();
    checks += 2;
    if (m_valM !== 64'h0) begin errors++; $display("FAIL rststore_nowrite got=%h want=0", m_valM); end
    if (m_valM !== x.mvalM) begin errors++; $display("FAIL rststore_model got=%h want=%h", m_valM, x.mvalM); end
  endtask

  task automatic test_store_load();
    exp_t x;
    drive(1'b1, 1'b0, AOK, 4'h4, 64'h40, 64'h1122334455667788, 4'hF, 4'hF);
    x = sbq.pop_front();
    checks += 2;
    if (m_stat !== AOK) begin errors++; $display("FAIL st_mstat got=%b want=1000", m_stat); end
    if (m_valM !== 64'h0) begin errors++; $display("FAIL st_valM got=%h want=0", m_valM); end
    drive(1'b1, 1'b0, AOK, 4'h5, 64'h40, 64'h0, 4'hF, 4'h3);
    x = sbq.pop_front();
    checks += 4;
    if (m_valM !== 64'h1122334455667788) begin errors++; $display("FAIL ld_valM got=%h want=1122334455667788", m_valM); end
    if (M_dstM !== 4'h3) begin errors++; $display("FAIL ld_dstM got=%h want=3", M_dstM); end
    if (dut.mem_q[64] !== 8'h88) begin errors++; $display("FAIL byte40 got=%h want=88", dut.mem_q[64]); end
    if (dut.mem_q[71] !== 8'h11) begin errors++; $display("FAIL byte47 got=%h want=11", dut.mem_q[71]); end
    drive(1'b1, 1'b0, AOK, 4'h5, 64'h43, 64'h0, 4'hF, 4'h3);
    x = sbq.pop_front();
    checks += 2;
    if (m_valM !== 64'h0000001122334455) begin errors++; $display("FAIL unaligned got=%h want=0000001122334455", m_valM); end
    if (m_valM !== x.mvalM) begin errors++; $display("FAIL unaligned_model got=%h want=%h", m_valM, x.mvalM); end
  endtask

  task automatic test_push_pop();
    exp_t x;
    drive(1'b1, 1'b0, AOK, 4'hA, 64'h1F8, 64'hDEAD, 4'h4, 4'hF);
    x = sbq.pop_front();
    drive(1'b1, 1'b0, AOK, 4'hB, 64'h200, 64'h1F8, 4'h4, 4'h1);
    x = sbq.pop_front();
    checks += 3;
    if (m_valM !== 64'hDEAD) begin errors++; $display("FAIL pop_valM got=%h want=dead", m_valM); end
    if (m_stat !== AOK) begin errors++; $display("FAIL pop_mstat got=%b want=1000", m_stat); end
    if (M_valE !== 64'h200) begin errors++; $display("FAIL pop_valE got=%h want=200", M_valE); end
    drive(1'b1, 1'b0, AOK, 4'h8, 64'h200, 64'h1234, 4'h4, 4'hF);
    x = sbq.pop_front();
    drive(1'b1, 1'b0, AOK, 4'h9, 64'h208, 64'h200, 4'h4, 4'hF);
    x = sbq.pop_front();
    checks += 1;
    if (m_valM !== 64'h1234) begin errors++; $display("FAIL ret_valM got=%h want=1234", m_valM); end
  endtask

  task automatic test_boundary();
    exp_t x;
    drive(1'b1, 1'b0, AOK, 4'h4, 64'h3F8, 64'h0102030405060708, 4'hF, 4'hF);
    x = sbq.pop_front();
    drive(1'b1, 1'b0, AOK, 4'h5, 64'h3F8, 64'h0, 4'hF, 4'h2);
    x = sbq.pop_front();
    checks += 2;
    if (m_stat !== AOK) begin errors++; $display("FAIL edge_ok_mstat got=%b want=1000", m_stat); end
    if (m_valM !== 64'h0102030405060708) begin errors++; $display("FAIL edge_ok_valM got=%h want=0102030405060708", m_valM); end
    drive(1'b1, 1'b0, AOK, 4'h5, 64'h3F9, 64'h0, 4'hF, 4'h2);
    x = sbq.pop_front();
    checks += 2;
    if (m_stat !== ADR) begin errors++; $display("FAIL edge_bad_mstat got=%b want=0010", m_stat); end
    if (m_valM !== 64'h0) begin errors++; $display("FAIL edge_bad_valM got=%h want=0", m_valM); end
    drive(1'b1, 1'b0, AOK, 4'h4, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFFF, 4'hF, 4'hF);
    x = sbq.pop_front();
    checks += 1;
    if (m_stat !== ADR) begin errors++; $display("FAIL wrap_mstat got=%b want=0010", m_stat); end
    drive(1'b1, 1'b0, AOK, 4'h9, 64'h0, 64'h400, 4'hF, 4'hF);
    x = sbq.pop_front();
    checks += 1;
    if (m_stat !== ADR) begin errors++; $display("FAIL ret_oob_mstat got=%b want=0010", m_stat); end
    drive(1'b1, 1'b0, AOK, 4'h5, 64'h3F8, 64'h0, 4'hF, 4'h2);
    x = sbq.pop_front();
    checks += 1;
    if (m_valM !== 64'h0102030405060708) begin errors++; $display("FAIL wrap_nowrite got=%h want=0102030405060708", m_valM); end
  endtask

  task automatic test_bubble();
    exp_t x;
    drive(1'b1, 1'b0, AOK, 4'h4, 64'h10, 64'hA5A5000011112222, 4'hF, 4'hF);
    x = sbq.pop_front();
    drive(1'b1, 1'b1, AOK, 4'h4, 64'h10, 64'h9999888877776666, 4'h2, 4'h3);
    x = sbq.pop_front();
    checks += 6;
    if (M_icode !== 4'h1) begin errors++; $display("FAIL bub_icode got=%h want=1", M_icode); end
    if (M_stat !== AOK) begin errors++; $display("FAIL bub_stat got=%b want=1000", M_stat); end
    if (M_dstE !== 4'hF) begin errors++; $display("FAIL bub_dstE got=%h want=f", M_dstE); end
    if (M_dstM !== 4'hF) begin errors++; $display("FAIL bub_dstM got=%h want=f", M_dstM); end
    if (M_valA !== 64'h0) begin errors++; $display("FAIL bub_valA got=%h want=0", M_valA); end
    if (M_Cnd !== 1'b0) begin errors++; $display("FAIL bub_cnd got=%b want=0", M_Cnd); end
    drive(1'b1, 1'b1, HLT, 4'h0, 64'h0, 64'h0, 4'h1, 4'h1);
    x = sbq.pop_front();
    checks += 2;
    if (M_stat !== AOK) begin errors++; $display("FAIL bub_hlt_Mstat got=%b want=1000", M_stat); end
    if (m_stat !== AOK) begin errors++; $display("FAIL bub_hlt_mstat got=%b want=1000", m_stat); end
    drive(1'b1, 1'b0, AOK, 4'h5, 64'h10, 64'h0, 4'hF, 4'h2);
    x = sbq.pop_front();
    checks += 1;
    if (m_valM !== 64'hA5A5000011112222) begin errors++; $display("FAIL bub_nowrite got=%h want=a5a5000011112222", m_valM); end
  endtask

  task automatic test_status();
    exp_t x;
    drive(1'b1, 1'b0, AOK, 4'h4, 64'h20, 64'h0BADF00D, 4'hF, 4'hF);
    x = sbq.pop_front();
    drive(1'b1, 1'b0, INS, 4'h4, 64'h20, 64'h77, 4'hF, 4'hF);
    x = sbq.pop_front();
    checks += 2;
    if (m_stat !== INS) begin errors++; $display("FAIL ins_mstat got=%b want=0001", m_stat); end
    if (m_valM !== 64'h0) begin errors++; $display("FAIL ins_valM got=%h want=0", m_valM); end
    drive(1'b1, 1'b0, INS, 4'h5, 64'h20, 64'h0, 4'hF, 4'h2);
    x = sbq.pop_front();
    checks += 1;
    if (m_valM !== 64'h0) begin errors++; $display("FAIL ins_ld_valM got=%h want=0", m_valM); end
    drive(1'b1, 1'b0, HLT, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    x = sbq.pop_front();
    checks += 1;
    if (m_stat !== HLT) begin errors++; $display("FAIL hlt_mstat got=%b want=0100", m_stat); end
    drive(1'b1, 1'b0, AOK, 4'h5, 64'h20, 64'h0, 4'hF, 4'h2);
    x = sbq.pop_front();
    checks += 1;
    if (m_valM !== 64'h0BADF00D) begin errors++; $display("FAIL ins_nowrite got=%h want=0badf00d", m_valM); end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    logic [3:0]  ics [8];
    logic [3:0]  ic, st;
    logic [63:0] a;
    ics = '{4'h1, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'h6};
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, AOK, 4'h4, 64'h80, 64'h5555AAAA5555AAAA, 4'h5, 4'hF);
      x = sbq.pop_front();
      checks += 2;
      if (M_valA !== 64'h5555AAAA5555AAAA) begin errors++; $display("FAIL held_valA got=%h want=5555aaaa5555aaaa", M_valA); end
      if (M_dstE !== 4'h5) begin errors++; $display("FAIL held_dstE got=%h want=5", M_dstE); end
    end
    drive(1'b1, 1'b0, AOK, 4'hB, 64'h0, 64'h80, 4'hF, 4'h6);
    x = sbq.pop_front();
    checks += 1;
    if (m_valM !== 64'h5555AAAA5555AAAA) begin errors++; $display("FAIL held_load got=%h want=5555aaaa5555aaaa", m_valM); end
    for (int i = 0; i < 60; i++) begin
      ic = ics[$urandom_range(0, 7)];
      st = ($urandom_range(0, 7) == 0) ? INS : AOK;
      a  = ($urandom_range(0, 9) == 0) ? 64'hFFFFFFFFFFFFFFF8 : 64'($urandom_range(0, 1023));
      drive(1'b1, 1'($urandom_range(0, 9) == 0), st, ic, a, {32'h0, $urandom}, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      x = sbq.pop_front();
      checks += 5;
      if (M_stat !== x.stat || M_icode !== x.icode) begin
        errors++; $display("FAIL rnd_stat_icode got=%b/%h want=%b/%h", M_stat, M_icode, x.stat, x.icode);
      end
      if (M_valE !== x.valE || M_valA !== x.valA || M_Cnd !== x.cnd) begin
        errors++; $display("FAIL rnd_vals got=%h/%h/%b want=%h/%h/%b", M_valE, M_valA, M_Cnd, x.valE, x.valA, x.cnd);
      end
      if (M_dstE !== x.dstE || M_dstM !== x.dstM) begin
        errors++; $display("FAIL rnd_dst got=%h/%h want=%h/%h", M_dstE, M_dstM, x.dstE, x.dstM);
      end
      if (m_stat !== x.mstat) begin errors++; $display("FAIL rnd_mstat got=%b want=%b", m_stat, x.mstat); end
      if (m_valM !== x.mvalM) begin errors++; $display("FAIL rnd_valM got=%h want=%h", m_valM, x.mvalM); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    pend = 1'b0; pend_addr = '0; pend_data = '0;
    rst_n = 1'b0; M_bubble = 1'b0; e_stat = AOK; e_icode = 4'h1; e_Cnd = 1'b0;
    e_valE = '0; e_valA = '0; e_dstE = 4'hF; e_dstM = 4'hF;
    test_reset();
    test_store_load();
    test_push_pop();
    test_boundary();
    test_bubble();
    test_status();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
